mem_responder: RTL and testbench
================================

# mem_responder

Word-addressed memory responder that sits on the far side of the CPU memory port and answers `mem_read` / `mem_write` requests. It holds a local word array and returns `mem_resp` after a fixed, parameterised latency. Byte-enabled writes are supported. It is used as the memory endpoint for CPU-level simulation and as the template for the cache-facing responder.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index bits; the array holds 2^ADDR_WIDTH 32-bit words (default 4 KiB).
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be aligned to 4·2^ADDR_WIDTH.
- `LATENCY`, 3: cycles from first request cycle to `mem_resp` cycle; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `mem_read`  in  1  read request; held until the `mem_resp` cycle.
- `mem_write`  in  1  write request; held until the `mem_resp` cycle.
- `mem_byte_enable`  in  4  write lane enables; bit i selects `mem_wdata[8i+7:8i]`.
- `mem_address`  in  32  byte address; bits [1:0] ignored.
- `mem_wdata`  in  32  write data.
- `mem_resp`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data; valid in the `mem_resp` cycle of a read.
- `err`  out  1  sticky protocol or range error.
- `err_cause`  out  3  sticky cause mask: [0] read and write both high, [1] request changed or dropped while busy, [2] address out of range.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If `mem_read` or `mem_write` is high, capture address, wdata, byte enable and direction.
  - Load the counter with LATENCY-1.
  - Go to RESP if LATENCY=1, else go to BUSY.
- BUSY: decrement the counter each cycle; go to RESP when the counter reaches 1.
- RESP:
  - Assert `mem_resp` for exactly this cycle.
  - Read: `mem_rdata` = array[index], whole word, byte enables ignored.
  - Write: array[index] is updated on the edge that ends this cycle, only for lanes whose enable bit is set.
  - Go to IDLE.
- Index = (`mem_address` - BASE_ADDR) >> 2, truncated to ADDR_WIDTH bits. Out-of-range addresses alias.
- Both `mem_read` and `mem_write` high: the request is treated as a write.
- Request inputs are sampled only in IDLE. Changes while in BUSY/RESP are ignored; the captured values are used.
- `mem_rdata` is a register. It holds its last read value through write responses and idle cycles.
- Array contents are not reset. Tests must write a location before reading it.

## Timing
- Reset values: `mem_resp`=0, `mem_rdata`=0, `err`=0, `err_cause`=0, state IDLE, counter 0.
- A request first high in cycle t produces `mem_resp` in cycle t+LATENCY.
- The responder is back in IDLE at t+LATENCY+1, so a new request asserted in cycle t+LATENCY+1 is accepted with no gap.
- A request still high in cycle t+LATENCY+1 counts as a new request. The requester must drop it after seeing `mem_resp`.
- A write committed at the end of cycle t+LATENCY is visible to a read accepted in cycle t+LATENCY+1.
- Reset asserted mid-transaction:
  - The transaction is aborted and no array write occurs.
  - `mem_resp` is 0 from the next cycle.
  - Reset wins over a RESP cycle in the same edge.
- The array is never written outside RESP and has no read-port conflicts (single transaction in flight).

## Configuration
- Macro: `MEM_RESP_PROTOCOL_CHECK_EN`.
- Defined: the checker is compiled in and sets `err` and the `err_cause` bits. Flags are sticky until `rst`.
  - [0] is set when read and write are both high in an accepted cycle.
  - [1] is set when, in any BUSY or RESP cycle, the request drops or address/wdata/byte-enable/direction differs from the captured values.
  - [2] is set when the accepted address is outside [BASE_ADDR, BASE_ADDR + 4·2^ADDR_WIDTH).
- Undefined: the checker is removed. `err` and `err_cause` are tied 0. Functional behaviour is identical.

## Test plan
- Reset, then write 32'hDEADBEEF, BE=4'hF, to 0x40. Read 0x40. Required: `mem_resp` exactly 3 cycles after each request, `mem_rdata`=32'hDEADBEEF.
- Write 32'h11223344 to 0x80, then write 32'hAABBCCDD with BE=4'b0101, then read 0x80. Required: 32'h11BB33DD.
- Back-to-back: read asserted the cycle after the previous `mem_resp`. Required: accepted immediately, second `mem_resp` LATENCY cycles later, no dropped or duplicated response.
- LATENCY=1 build: read of address 0x0 written earlier returns its value with `mem_resp` in the cycle after the request appears.
- Assert `rst` in a BUSY cycle of a write of 32'hCAFEF00D to 0x10. Required: no `mem_resp`, and a later read of 0x10 returns the prior value (32'h0 after a preceding write of 0).
- With `MEM_RESP_PROTOCOL_CHECK_EN`:
  - Change `mem_address` mid-BUSY: required `err`=1, `err_cause`=3'b010.
  - Access 0x1000 with ADDR_WIDTH=10: required `err_cause[2]`=1.
  - Both flags must clear only on `rst`.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bundle between a CPU-side memory port and its responder.
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        err;
    logic [2:0]  err_cause;

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  mem_resp, mem_rdata, err, err_cause
    );

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output mem_resp, mem_rdata, err, err_cause
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-array memory responder with byte-enabled writes.
// Optional protocol/range checker compiled in with MEM_RESP_PROTOCOL_CHECK_EN.
module mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned LATENCY    = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              be_q, be_d;
    logic                    is_wr_q, is_wr_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             mem_array [DEPTH];

    logic                    req;
    logic [31:0]             offset;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic                    unused_lsbs;

    assign req         = bus.mem_read | bus.mem_write;
    assign offset      = bus.mem_address - BASE_ADDR;
    assign req_idx     = offset[ADDR_WIDTH+1:2];
    assign unused_lsbs = ^offset[1:0];

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = req_idx;
                    wdata_d = bus.mem_wdata;
                    be_d    = bus.mem_byte_enable;
                    is_wr_d = bus.mem_write;
                    cnt_d   = LAT_M1;
                    state_d = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read data is registered on entry to RESP so it is stable for the whole pulse.
        if (state_d == RESP && !is_wr_d) rdata_d = mem_array[idx_d];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
        end
    end

    // NOTE: the array is deliberately not reset; reset only blocks the commit of an aborted write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && is_wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_array[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign bus.mem_resp  = (state_q == RESP);
    assign bus.mem_rdata = rdata_q;

`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    logic [2:0]  err_cause_q, err_cause_d;
    logic [31:0] addr_q, addr_d;

    always_comb begin
        err_cause_d = err_cause_q;
        addr_d      = addr_q;
        if (state_q == IDLE && req) begin
            addr_d = bus.mem_address;
            if (bus.mem_read && bus.mem_write) err_cause_d[0] = 1'b1;
            if ((offset >> (ADDR_WIDTH + 2)) != 32'd0) err_cause_d[2] = 1'b1;
        end
        if (state_q == BUSY || state_q == RESP) begin
            if (!req ||
                bus.mem_address     != addr_q  ||
                bus.mem_wdata       != wdata_q ||
                bus.mem_byte_enable != be_q    ||
                bus.mem_write       != is_wr_q) err_cause_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cause_q <= '0;
            addr_q      <= '0;
        end else begin
            err_cause_q <= err_cause_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.err       = |err_cause_q;
    assign bus.err_cause = err_cause_q;
`else
    logic unused_offset_hi;
    assign unused_offset_hi = ^offset[31:ADDR_WIDTH+2];
    assign bus.err          = 1'b0;
    assign bus.err_cause    = 3'b000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: a LATENCY=3 and a LATENCY=1 responder checked every cycle against a
// transaction-level memory model, plus literal expectations from hand-worked vectors.
module tb_mem_responder;

    localparam int LAT0 = 3;
    localparam int LAT1 = 1;
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_responder_if bus0 ();
    mem_responder_if bus1 ();

    mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(bus0));
    mem_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit en          = 1'b0;

    // Transaction-level model: one pending request per DUT, due at issue cycle + latency.
    int          lat      [2] = '{LAT0, LAT1};
    bit          pend_v   [2];
    int          pend_cyc [2];
    bit          pend_wr  [2];
    int          pend_idx [2];
    logic [3:0]  pend_be  [2];
    logic [31:0] pend_wd  [2];
    logic [31:0] mrd      [2];
    logic [2:0]  merr     [2];
    logic [31:0] mmem     [int];

    logic        resp_a  [2];
    logic [31:0] rdata_a [2];
    logic        err_a   [2];
    logic [2:0]  cause_a [2];
    assign resp_a[0]  = bus0.mem_resp;   assign resp_a[1]  = bus1.mem_resp;
    assign rdata_a[0] = bus0.mem_rdata;  assign rdata_a[1] = bus1.mem_rdata;
    assign err_a[0]   = bus0.err;        assign err_a[1]   = bus1.err;
    assign cause_a[0] = bus0.err_cause;  assign cause_a[1] = bus1.err_cause;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'd1024);
    endfunction

    function automatic logic [31:0] mget(input int key);
        return mmem.exists(key) ? mmem[key] : 32'h0;
    endfunction

    task automatic drive(input int d, input bit rd, input bit wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_byte_enable = be;
            bus0.mem_address = a; bus0.mem_wdata = wd;
        end else begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_byte_enable = be;
            bus1.mem_address = a; bus1.mem_wdata = wd;
        end
    endtask

    task automatic issue(input int d, input bit wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        pend_v[d]   = 1'b1;
        pend_cyc[d] = cyc + lat[d];
        pend_wr[d]  = wr;
        pend_idx[d] = widx(a);
        pend_be[d]  = be;
        pend_wd[d]  = wd;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge ending the RESP cycle.
    task automatic txn(input int d, input bit rd, input bit wr, input logic [3:0] be,
                       input logic [31:0] a, input logic [31:0] wd, input logic [2:0] acc_err);
        drive(d, rd, wr, be, a, wd);
        issue(d, wr, be, a, wd);
        @(posedge clk);
        merr[d] = merr[d] | (acc_err & {3{CHK}});
        repeat (lat[d]) @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            pend_v[d] = 1'b0; mrd[d] = 32'h0; merr[d] = 3'b000;
        end
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                logic        exp_resp;
                int          key;
                logic [31:0] w;
                exp_resp = pend_v[d] && (cyc == pend_cyc[d]);
                if (exp_resp) begin
                    pend_v[d] = 1'b0;
                    key = d * 65536 + pend_idx[d];
                    if (pend_wr[d]) begin
                        w = mget(key);
                        for (int i = 0; i < 4; i++)
                            if (pend_be[d][i]) w[8*i +: 8] = pend_wd[d][8*i +: 8];
                        mmem[key] = w;
                    end else begin
                        mrd[d] = mget(key);
                    end
                end
                check($sformatf("dut%0d mem_resp", d),  32'(resp_a[d]),  32'(exp_resp));
                check($sformatf("dut%0d mem_rdata", d), rdata_a[d],      mrd[d]);
                check($sformatf("dut%0d err", d),       32'(err_a[d]),   32'(|merr[d]));
                check($sformatf("dut%0d err_cause", d), 32'(cause_a[d]), 32'(merr[d]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        for (int d = 0; d < 2; d++) begin
            pend_v[d] = 1'b0; mrd[d] = 32'h0; merr[d] = 3'b000;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        check("reset mem_resp",  32'(bus0.mem_resp), 32'd0);
        check("reset mem_rdata", bus0.mem_rdata, 32'h0);
        check("reset err_cause", 32'(bus0.err_cause), 32'd0);

        // Full-word write then read.
        txn(0, 1'b0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, 3'b000);
        txn(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 3'b000);
        check("read 0x40", bus0.mem_rdata, 32'hDEADBEEF);

        // Byte-lane merge.
        txn(0, 1'b0, 1'b1, 4'hF,    32'h80, 32'h11223344, 3'b000);
        txn(0, 1'b0, 1'b1, 4'b0101, 32'h80, 32'hAABBCCDD, 3'b000);
        txn(0, 1'b1, 1'b0, 4'hF,    32'h80, 32'h0, 3'b000);
        check("byte merge 0x80", bus0.mem_rdata, 32'h11BB33DD);

        // Back-to-back requests with no idle gap; write visible to the next read.
        txn(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0, 3'b000);
        txn(0, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 3'b000);
        check("b2b read 0x80", bus0.mem_rdata, 32'h11BB33DD);
        txn(0, 1'b0, 1'b1, 4'hF, 32'h84, 32'h77777777, 3'b000);
        txn(0, 1'b1, 1'b0, 4'hF, 32'h84, 32'h0, 3'b000);
        check("b2b write->read 0x84", bus0.mem_rdata, 32'h77777777);
        idle(2);
        txn(0, 1'b0, 1'b1, 4'hF, 32'h88, 32'h12345678, 3'b000);
        check("rdata holds over write", bus0.mem_rdata, 32'h77777777);

        // LATENCY=1 responder.
        txn(1, 1'b0, 1'b1, 4'hF, 32'h0, 32'h13572468, 3'b000);
        idle(1);
        txn(1, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 3'b000);
        check("lat1 read 0x0", bus1.mem_rdata, 32'h13572468);
        txn(1, 1'b0, 1'b1, 4'hF, 32'h4, 32'hA5A5A5A5, 3'b000);
        txn(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 3'b000);
        check("lat1 b2b read 0x4", bus1.mem_rdata, 32'hA5A5A5A5);

        // Reset during BUSY of a write aborts it.
        txn(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'h0, 3'b000);
        drive(0, 1'b0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D);
        issue(0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D);
        idle(1);
        do_reset();
        check("no resp after reset", 32'(bus0.mem_resp), 32'd0);
        idle(4);
        txn(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 3'b000);
        check("aborted write 0x10", bus0.mem_rdata, 32'h0);

        // Request changes mid-BUSY are ignored (and flagged when the checker is built).
        txn(0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h5A5A0001, 3'b000);
        drive(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
        issue(0, 1'b0, 4'hF, 32'h40, 32'h0);
        idle(1);
        bus0.mem_address = 32'h80;
        @(posedge clk);
        merr[0] = merr[0] | (3'b010 & {3{CHK}});
        repeat (LAT0 - 1) @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        check("captured addr used", bus0.mem_rdata, 32'hDEADBEEF);
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        check("mid-busy err", 32'(bus0.err), 32'd1);
        check("mid-busy err_cause", 32'(bus0.err_cause), 32'(3'b010));
`endif

        // Out-of-range access aliases onto word 0.
        txn(0, 1'b1, 1'b0, 4'hF, 32'h1000, 32'h0, 3'b100);
        check("alias 0x1000", bus0.mem_rdata, 32'h5A5A0001);
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        check("range err_cause[2]", 32'(bus0.err_cause[2]), 32'd1);
`endif

        // Read and write together behave as a write.
        txn(0, 1'b1, 1'b1, 4'hF, 32'h80, 32'h0F0F0F0F, 3'b001);
        txn(0, 1'b1, 1'b0, 4'hF, 32'h80, 32'h0, 3'b000);
        check("rd+wr is write", bus0.mem_rdata, 32'h0F0F0F0F);
        idle(3);
`ifdef MEM_RESP_PROTOCOL_CHECK_EN
        check("sticky err_cause", 32'(bus0.err_cause), 32'(3'b111));
`endif

        do_reset();
        check("err cleared by rst", 32'(bus0.err), 32'd0);
        check("cause cleared by rst", 32'(bus0.err_cause), 32'd0);
        check("rdata cleared by rst", bus0.mem_rdata, 32'h0);
        idle(2);
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
